input_debounce: RTL

Synchronises and debounces the raw board switches and push-buttons before they reach the LED/priority-encoder stage. Each of the 8 switch bits and 5 button bits passes through a two-flop synchroniser and an independent per-bit stability counter. A bit's debounced output changes only after the synchronised input has held a new value for a full debounce window. The block drives the encoder's `sw` input and `btn` input directly, and also provides single-cycle button-press pulses and a switch-change strobe.

---
 rtl/input_debounce.sv | 90 +++++++++
 1 files changed

// File: rtl/input_debounce.sv
// Two-flop synchroniser plus per-bit stability counter for board switches and buttons.
// Debounced levels, button-press pulses and a switch-change strobe all come from flops.
module input_debounce #(
  parameter int unsigned SW_W    = 8,
  parameter int unsigned BTN_W   = 5,
  parameter int unsigned CNT_MAX = 50000,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [SW_W-1:0]  sw_raw,
  input  logic [BTN_W-1:0] btn_raw,
  output logic [SW_W-1:0]  sw_db,
  output logic [BTN_W-1:0] btn_db,
  output logic [BTN_W-1:0] btn_rise,
  output logic             sw_chg
);

  localparam int unsigned N = SW_W + BTN_W;
  localparam logic [CNT_W-1:0] CntLast = CNT_W'(CNT_MAX - 1);

  // Buttons occupy the upper bits of every per-channel vector.
  logic [N-1:0]     raw;
  logic [N-1:0]     s1_q;
  logic [N-1:0]     s2_q;
  logic [N-1:0]     st_q;
  logic [N-1:0]     st_d;
  logic [BTN_W-1:0] btn_rise_q;
  logic [BTN_W-1:0] btn_rise_d;
  logic             sw_chg_q;
  logic             sw_chg_d;

  assign raw = {btn_raw, sw_raw};

  for (genvar i = 0; i < N; i++) begin : g_chan
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             st_nxt;

    // Any agreeing sample clears the count, so only an unbroken run qualifies.
    always_comb begin
      cnt_d  = '0;
      st_nxt = st_q[i];
      if (s2_q[i] != st_q[i]) begin
        if (cnt_q == CntLast) begin
          st_nxt = s2_q[i];
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    end

    assign st_d[i] = st_nxt;

    always_ff @(posedge clk) begin
      if (rst) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_d;
      end
    end
  end

  always_comb begin
    btn_rise_d = st_d[N-1:SW_W] & ~st_q[N-1:SW_W];
    sw_chg_d   = |(st_d[SW_W-1:0] ^ st_q[SW_W-1:0]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q       <= '0;
      s2_q       <= '0;
      st_q       <= '0;
      btn_rise_q <= '0;
      sw_chg_q   <= 1'b0;
    end else begin
      s1_q       <= raw;
      s2_q       <= s1_q;
      st_q       <= st_d;
      btn_rise_q <= btn_rise_d;
      sw_chg_q   <= sw_chg_d;
    end
  end

  assign sw_db    = st_q[SW_W-1:0];
  assign btn_db   = st_q[N-1:SW_W];
  assign btn_rise = btn_rise_q;
  assign sw_chg   = sw_chg_q;

endmodule
